// File: rtl/io_sw_debounce.sv
// ----------------------------------------------------------------------------
// io_sw_debounce
//
// Conditions the raw board switch lines before they reach the processor's
// memory-mapped switch register. The block works in three stages:
//   1. A two-flop synchroniser brings the raw lines into the i_clk domain.
//   2. A shared prescaler produces a sample tick every TICK_DIV cycles.
//   3. A per-bit stability counter accepts a new level only after it has
//      been seen on STABLE_CNT consecutive ticks.
//
// Optional feature (macro IO_SW_EDGE_EN):
//   Defined   : adds registered per-bit rise/fall pulses and an event flag.
//   Undefined : o_sw_rise, o_sw_fall and o_sw_event are tied to 0, and no
//               edge registers are generated.
//
// Parameters:
//   N          number of switch bits
//   TICK_DIV   i_clk cycles per debounce sample tick (>= 1)
//   STABLE_CNT consecutive mismatching ticks needed to accept a level (>= 1)
//
// Ports:
//   i_clk       system clock
//   i_rst       asynchronous, active-high reset; clears all state
//   i_sw_raw    raw, asynchronous switch inputs
//   o_io_sw     debounced switch word
//   o_sw_rise   one-cycle pulse per bit on an accepted 0->1 change
//   o_sw_fall   one-cycle pulse per bit on an accepted 1->0 change
//   o_sw_event  OR of all rise and fall bits, aligned with them
// ----------------------------------------------------------------------------
module io_sw_debounce #(
    parameter int unsigned N          = 32,
    parameter int unsigned TICK_DIV   = 500,
    parameter int unsigned STABLE_CNT = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_sw_raw,
    output logic [N-1:0] o_io_sw,
    output logic [N-1:0] o_sw_rise,
    output logic [N-1:0] o_sw_fall,
    output logic         o_sw_event
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CW = ($clog2(STABLE_CNT + 1) > 1) ? $clog2(STABLE_CNT + 1) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

    logic [N-1:0]          sync1_q;
    logic [N-1:0]          sync2_q;
    logic [PW-1:0]         pre_q;
    logic [PW-1:0]         pre_d;
    logic                  tick;
    logic [N-1:0][CW-1:0]  cnt_q;
    logic [N-1:0][CW-1:0]  cnt_d;
    logic [N-1:0]          sw_q;
    logic [N-1:0]          sw_d;

    // With TICK_DIV = 1 the counter is pinned at 0 and tick is always high.
    always_comb begin
        tick  = (pre_q == PRE_LAST);
        pre_d = tick ? '0 : pre_q + PW'(1);
    end

    // Each bit counts consecutive ticks on which the synchronised input
    // disagrees with the accepted level; any agreeing tick clears the count.
    always_comb begin
        sw_d  = sw_q;
        cnt_d = cnt_q;
        if (tick) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (sync2_q[i] == sw_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    sw_d[i]  = sync2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            pre_q   <= '0;
            cnt_q   <= '0;
            sw_q    <= '0;
        end else begin
            sync1_q <= i_sw_raw;
            sync2_q <= sync1_q;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            sw_q    <= sw_d;
        end
    end

    assign o_io_sw = sw_q;

`ifdef IO_SW_EDGE_EN
    logic [N-1:0] rise_d;
    logic [N-1:0] fall_d;
    logic         event_d;
    logic [N-1:0] rise_q;
    logic [N-1:0] fall_q;
    logic         event_q;

    // Pulses come from the next-state word so that they register on the
    // same edge that updates o_io_sw.
    always_comb begin
        rise_d  = sw_d & ~sw_q;
        fall_d  = ~sw_d & sw_q;
        event_d = |(rise_d | fall_d);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rise_q  <= '0;
            fall_q  <= '0;
            event_q <= 1'b0;
        end else begin
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            event_q <= event_d;
        end
    end

    assign o_sw_rise  = rise_q;
    assign o_sw_fall  = fall_q;
    assign o_sw_event = event_q;
`else
    assign o_sw_rise  = '0;
    assign o_sw_fall  = '0;
    assign o_sw_event = 1'b0;
`endif

endmodule

// File: tb/tb_io_sw_debounce.sv
// ----------------------------------------------------------------------------
// tb_io_sw_debounce
//
// Drives two instances from the same raw switch word:
//   A : TICK_DIV = 1, STABLE_CNT = 4
//   B : TICK_DIV = 3, STABLE_CNT = 2
// The reference model works on a sliding window of tick samples. A bit
// flips when every one of the last STABLE_CNT tick samples disagrees with
// the currently accepted level.
// ----------------------------------------------------------------------------
module tb_io_sw_debounce;

`ifdef IO_SW_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] sw_raw = '0;

    logic [31:0] a_sw, a_rise, a_fall;
    logic        a_ev;
    logic [31:0] b_sw, b_rise, b_fall;
    logic        b_ev;

    always #5 clk = ~clk;

    io_sw_debounce #(.N(32), .TICK_DIV(1), .STABLE_CNT(4)) u_dut_a (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_sw_raw   (sw_raw),
        .o_io_sw    (a_sw),
        .o_sw_rise  (a_rise),
        .o_sw_fall  (a_fall),
        .o_sw_event (a_ev)
    );

    io_sw_debounce #(.N(32), .TICK_DIV(3), .STABLE_CNT(2)) u_dut_b (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_sw_raw   (sw_raw),
        .o_io_sw    (b_sw),
        .o_sw_rise  (b_rise),
        .o_sw_fall  (b_fall),
        .o_sw_event (b_ev)
    );

    int n_chk  = 0;
    int n_fail = 0;

    int unsigned td[2] = '{1, 3};
    int unsigned sc[2] = '{4, 2};

    // Model state, one slot per instance.
    logic [31:0] m_s1[2];
    logic [31:0] m_s2[2];
    logic [31:0] m_acc[2];
    logic [31:0] m_rise[2];
    logic [31:0] m_fall[2];
    logic        m_ev[2];
    int unsigned m_ecnt[2];
    logic [31:0] m_win[2][4];
    int unsigned m_wn[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_s1[m]   = '0;
            m_s2[m]   = '0;
            m_acc[m]  = '0;
            m_rise[m] = '0;
            m_fall[m] = '0;
            m_ev[m]   = 1'b0;
            m_ecnt[m] = 0;
            m_wn[m]   = 0;
            for (int j = 0; j < 4; j++) m_win[m][j] = '0;
        end
    endtask

    // One active clock edge: raw is the value present at that edge.
    task automatic model_edge(input logic [31:0] raw);
        logic [31:0] old_acc;
        logic [31:0] new_acc;
        logic        all_diff;
        for (int m = 0; m < 2; m++) begin
            old_acc = m_acc[m];
            new_acc = old_acc;
            if ((m_ecnt[m] % td[m]) == td[m] - 1) begin
                for (int j = 3; j > 0; j--) m_win[m][j] = m_win[m][j-1];
                m_win[m][0] = m_s2[m];
                if (m_wn[m] < 4) m_wn[m]++;
                if (m_wn[m] >= sc[m]) begin
                    for (int b = 0; b < 32; b++) begin
                        all_diff = 1'b1;
                        for (int j = 0; j < int'(sc[m]); j++)
                            if (m_win[m][j][b] == old_acc[b]) all_diff = 1'b0;
                        if (all_diff) new_acc[b] = ~old_acc[b];
                    end
                end
            end
            m_ecnt[m]++;
            m_acc[m]  = new_acc;
            m_rise[m] = EDGE_EN ? (new_acc & ~old_acc) : '0;
            m_fall[m] = EDGE_EN ? (~new_acc & old_acc) : '0;
            m_ev[m]   = |(m_rise[m] | m_fall[m]);
            m_s2[m]   = m_s1[m];
            m_s1[m]   = raw;
        end
    endtask

    task automatic check_all();
        check("a_sw",   a_sw,   m_acc[0]);
        check("a_rise", a_rise, m_rise[0]);
        check("a_fall", a_fall, m_fall[0]);
        check("a_ev",   {31'b0, a_ev}, {31'b0, m_ev[0]});
        check("b_sw",   b_sw,   m_acc[1]);
        check("b_rise", b_rise, m_rise[1]);
        check("b_fall", b_fall, m_fall[1]);
        check("b_ev",   {31'b0, b_ev}, {31'b0, m_ev[1]});
    endtask

    // Drive raw before the edge, update the model on the edge, sample 1 later.
    task automatic cycle(input logic [31:0] raw);
        sw_raw = raw;
        @(posedge clk);
        if (!rst) model_edge(raw);
        #1;
        check_all();
    endtask

    logic [31:0] cur;
    int unsigned hold;

    initial begin
        model_reset();

        // Reset held with all raw lines high.
        rst = 1'b1;
        for (int j = 0; j < 3; j++) begin
            cycle(32'hFFFF_FFFF);
            check("rst_sw", a_sw, 32'h0);
            check("rst_ev", {31'b0, a_ev}, 32'h0);
        end
        cycle(32'h0);
        #2 rst = 1'b0;

        // Clean change.
        for (int j = 0; j < 3; j++) cycle(32'h0);
        for (int j = 0; j < 8; j++) begin
            cycle(32'h0000_0005);
            if (j == 4) check("clean_early", a_sw, 32'h0);
            if (j == 5) begin
                check("clean_acc",  a_sw,   32'h0000_0005);
                check("clean_rise", a_rise, EDGE_EN ? 32'h0000_0005 : 32'h0);
                check("clean_ev",   {31'b0, a_ev}, {31'b0, EDGE_EN});
            end
        end

        // Glitch on bit 3, then a stable high.
        for (int j = 0; j < 3; j++) cycle(32'h0000_000D);
        for (int j = 0; j < 6; j++) cycle(32'h0000_0005);
        check("glitch_hold", a_sw, 32'h0000_0005);
        for (int j = 0; j < 6; j++) cycle(32'h0000_000D);
        check("glitch_late", a_sw, 32'h0000_000D);

        // Simultaneous rise and fall.
        for (int j = 0; j < 6; j++) cycle(32'h0000_00F0);
        check("sim_pre", a_sw, 32'h0000_00F0);
        for (int j = 0; j < 6; j++) begin
            cycle(32'h0000_000F);
            if (j == 5) begin
                check("sim_sw",   a_sw,   32'h0000_000F);
                check("sim_rise", a_rise, EDGE_EN ? 32'h0000_000F : 32'h0);
                check("sim_fall", a_fall, EDGE_EN ? 32'h0000_00F0 : 32'h0);
            end
        end
        for (int j = 0; j < 10; j++) cycle(32'h0000_000F);
        check("pre_settle", b_sw, 32'h0000_000F);

        // Randomised bursts: sparse bit flips held for random durations.
        cur = 32'h0000_000F;
        for (int it = 0; it < 400; it++) begin
            cur  = cur ^ ($urandom & $urandom & $urandom);
            hold = $urandom_range(1, 8);
            for (int unsigned j = 0; j < hold; j++) cycle(cur);
        end

        // Asynchronous reset with bit 0 of A two ticks into a count.
        for (int j = 0; j < 10; j++) cycle(32'h0000_00F0);
        check("arst_pre", a_sw, 32'h0000_00F0);
        for (int j = 0; j < 4; j++) cycle(32'h0000_00F1);
        check("arst_cnt", a_sw, 32'h0000_00F0);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check("arst_a_sw", a_sw, 32'h0);
        check("arst_b_sw", b_sw, 32'h0);
        check_all();
        cycle(32'h0000_00F1);
        #2 rst = 1'b0;
        for (int j = 0; j < 7; j++) begin
            cycle(32'h0000_00F1);
            if (j == 4) check("arst_early", a_sw, 32'h0);
            if (j == 5) check("arst_acc",   a_sw, 32'h0000_00F1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/io_sw_debounce.md
# io_sw_debounce

Input conditioner directly upstream of the `pipline` core's `i_io_sw` port. It takes the raw board switch lines and synchronises them into `i_clk` with a two-flop chain. It then debounces each bit independently against a shared sample tick, and presents a clean, stable switch word to the processor's memory-mapped input register. An optional edge-event stage reports per-bit rise and fall pulses.

## Interface
Parameters:
- `N`, 32, number of switch bits.
- `TICK_DIV`, 500, `i_clk` cycles per debounce sample tick; must be ≥1.
- `STABLE_CNT`, 4, consecutive mismatching ticks required to accept a new level; must be ≥1.

Ports:
- `i_clk`  in  1  single system clock.
- `i_rst`  in  1  asynchronous, active-high reset; clears all state.
- `i_sw_raw`  in  N  raw, asynchronous switch inputs.
- `o_io_sw`  out  N  debounced switch word; connects to `pipline.i_io_sw`.
- `o_sw_rise`  out  N  one-cycle pulse per bit on an accepted 0→1 change.
- `o_sw_fall`  out  N  one-cycle pulse per bit on an accepted 1→0 change.
- `o_sw_event`  out  1  OR of all `o_sw_rise` and `o_sw_fall` bits.

## Operation
- **Synchroniser:** `sync1 <= i_sw_raw`, then `sync2 <= sync1`. Both reset to 0.
- **Prescaler:**
  - Counter width is `$clog2(TICK_DIV)`, minimum 1 bit.
  - It counts 0..`TICK_DIV`-1 and wraps to 0.
  - `tick` is high in the cycle the count equals `TICK_DIV`-1.
  - With `TICK_DIV`=1, `tick` is high every cycle.
- **Per-bit stability counter:** `cnt[i]`, width `$clog2(STABLE_CNT+1)`. On each tick:
  - If `sync2[i]` equals `o_io_sw[i]`: `cnt[i]` ← 0.
  - Else if `cnt[i]` equals `STABLE_CNT`-1: `o_io_sw[i]` ← `sync2[i]` and `cnt[i]` ← 0.
  - Else: `cnt[i]` ← `cnt[i]`+1.
  - Between ticks, counters and outputs hold.
- **Glitch rejection:** a bit that returns to its accepted level before `STABLE_CNT` consecutive mismatching ticks clears its counter. No output change occurs.
- **Independence:** bits are fully independent, so any number of bits may be accepted on the same tick.
- **Edge pulses:** these are registered and computed on the same edge `o_io_sw` updates.
  - `o_sw_rise[i]` = 1 exactly when bit `i` is accepted 0→1.
  - `o_sw_fall[i]` = 1 exactly when bit `i` is accepted 1→0.
  - Both are high for exactly one cycle, then return to 0.
- **Event flag:** `o_sw_event` is registered from the same next-state, so it is aligned with the rise and fall pulses.

## Timing
- **Reset values:** all outputs, synchroniser flops, the prescaler and every `cnt[i]` are 0 while `i_rst` is high.
- **Reset mid-operation:** pending counts and in-flight edges are discarded immediately.
- **Sync latency:** a raw change set up before edge k appears in `sync2` after edge k+1.
- **Acceptance with `TICK_DIV`=1:** `o_io_sw` updates at edge k+1+`STABLE_CNT`.
- **Acceptance in general:** `o_io_sw` updates on the `STABLE_CNT`-th consecutive tick edge that samples a mismatch.
  - Worst-case latency is 2 + `TICK_DIV`·`STABLE_CNT` cycles.
- **Prescaler after reset:** the prescaler restarts from 0 on reset release. The first tick occurs `TICK_DIV` cycles later.
- **`STABLE_CNT`=1:** a mismatch is accepted on the first tick that sees it.
- **No handshake:** the output is level-valid every cycle.

## Configuration
- Macro: `IO_SW_EDGE_EN`.
- **Defined:** the rise/fall/event logic is compiled in and behaves as above.
- **Undefined:**
  - `o_sw_rise`, `o_sw_fall` and `o_sw_event` are tied to 0.
  - No edge registers are generated.
  - Debounce behaviour and the timing of `o_io_sw` are unchanged.

## Test plan
All scenarios use `N`=32, `TICK_DIV`=1, `STABLE_CNT`=4 unless noted.
- **Reset:** drive `i_sw_raw`=32'hFFFF_FFFF with `i_rst`=1 for 3 cycles → `o_io_sw`=0 and all pulses 0 throughout.
- **Clean change:** release reset with `i_sw_raw`=0. Set `i_sw_raw`=32'h0000_0005 before edge k.
  - Required: `o_io_sw`=32'h0000_0005 after edge k+5, not before.
  - With `IO_SW_EDGE_EN` defined: `o_sw_rise`=32'h0000_0005 and `o_sw_event`=1 for that one cycle only.
- **Glitch:** pulse bit 3 high for 3 cycles, then low → `o_io_sw[3]` stays 0 and no pulses.
  - A later 4-cycle-stable high is accepted normally.
- **Simultaneous rise and fall:** with `o_io_sw`=32'h0000_00F0, change the raw word to 32'h0000_000F → on one edge `o_io_sw`=32'h0000_000F, `o_sw_rise`=32'h0F and `o_sw_fall`=32'hF0.
- **Prescaled sampling:** with `TICK_DIV`=3, `STABLE_CNT`=2, a raw change before edge k is accepted by edge k+2+6.
  - A toggle lasting 4 cycles that spans only one tick is rejected.
- **Async reset mid-count:** assert `i_rst` asynchronously, mid-cycle, with `cnt[0]`=2 → outputs clear without waiting for a clock edge.
  - After release, bit 0 needs a full 4 mismatching ticks again before acceptance.
